bitwise_op_pipe: RTL

BITWISE_OP_PIPE -- requirements
Module: bitwise_op_pipe

---
 rtl/bitwise_pkg.sv | 13 +
 rtl/bitop_fifo.sv | 68 ++++++
 rtl/bitwise_op_pipe.sv | 79 +++++++
 3 files changed

// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise operation pipeline: op field width and op encodings.
package bitwise_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_ANDN = 2'b11
    } op_e;

endpackage : bitwise_pkg

// File: rtl/bitop_fifo.sv
// Small synchronous FIFO holding computed results until the consumer takes them.
// Occupancy is a registered counter, so full/empty never depend on same-cycle push/pop.
module bitop_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Gating the head with empty keeps the output at zero during and after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : bitop_fifo

// File: rtl/bitwise_op_pipe.sv
// Bitwise ALU with an accumulator feedback operand and a buffered result stream.
// Each accepted request's result and zero flag are queued together in bitop_fifo.
module bitwise_op_pipe
    import bitwise_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_zero,
    output logic [WIDTH-1:0] acc_q
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] op_result;
    logic             accept;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH:0]   head;

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign result    = head[WIDTH-1:0];
    assign out_zero  = head[WIDTH];
    assign acc_q     = acc;

    always_comb begin
        operand_b = use_acc ? acc : b;
        op_result = '0;
        case (op_e'(op))
            OP_AND:  op_result = a & operand_b;
            OP_OR:   op_result = a | operand_b;
            OP_XOR:  op_result = a ^ operand_b;
            OP_ANDN: op_result = a & ~operand_b;
            default: op_result = '0;
        endcase
    end

    // A clear wins over the load, but the same-edge operation already saw the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (accept) begin
            acc <= op_result;
        end
    end

    bitop_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .wr_data ({(op_result == '0), op_result}),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .rd_data (head)
    );

endmodule : bitwise_op_pipe
